cfg_chain_ctrl: RTL
===================

# cfg_chain_ctrl

Parametrised configuration-chain controller. It sits between the UART and one or more serially configured fabric blocks (connection blocks, logic blocks) and replaces the fixed-length decoder. It takes framed commands from the UART receive side and shifts configuration data into a chain of CHAIN_LEN bits. It returns the displaced chain contents byte-for-byte on the UART transmit side, and supports non-destructive readback and status reporting with error and timeout detection.

## Interface
- CHAIN_LEN, 32, total configuration chain length in bits; must be a positive multiple of 8 (elaboration error otherwise)
- TIMEOUT, 1000000, max SCLK cycles to wait for the next LOAD data byte before aborting
- SCLK  input  1  system clock; all state on rising edge
- RESET  input  1  synchronous, active-high reset
- RX_VALID  input  1  single-cycle strobe, RX_DATA valid
- RX_DATA  input  8  received byte
- TX_READY  input  1  UART transmitter can accept a byte
- TX_VALID  output  1  TX_DATA valid; held until accepted
- TX_DATA  output  8  byte to transmit
- SHIFT_HEAD  output  1  serial data into chain head (SIN)
- SHIFT_TAIL  input  1  serial data from chain tail (SOUT)
- SHIFT_ENABLE  output  1  chain clock enable (CE); one bit moves per high cycle
- BUSY  output  1  high in any state other than IDLE
- CFG_DONE  output  1  a LOAD completed since reset or since the last LOAD began
- ERROR  output  1  OR of the sticky error flags

## Operation
- NBYTES = CHAIN_LEN/8. Bits go LSB first. Byte k bit i drives SHIFT_HEAD on the cycle with global index 8k+i.
- Commands are accepted only in IDLE:
  - 0x01 LOAD: clears CFG_DONE and goes to LOAD_WAIT.
  - 0x02 READ: goes to SHIFT in rotate mode.
  - 0x03 STATUS: goes to SEND with the status byte.
  - Any other value sets the sticky UNKNOWN flag and stays in IDLE.
- States and transitions:
  - IDLE -> on command, as listed above.
  - LOAD_WAIT -> SHIFT on RX_VALID. The byte is latched and the timeout counter is cleared.
  - LOAD_WAIT -> IDLE when the counter reaches TIMEOUT. This sets the sticky TOUT flag and leaves CFG_DONE low.
  - SHIFT runs 8 cycles with SHIFT_ENABLE=1.
    - Load mode: SHIFT_HEAD = latched bit i.
    - Rotate mode: SHIFT_HEAD = SHIFT_TAIL, combinational, so the chain recirculates.
    - Every cycle, SHIFT_TAIL is captured into readback bit i.
  - SHIFT -> SEND after the 8th bit.
  - SEND asserts TX_VALID with the readback byte (or the status byte). The transfer occurs on a cycle where TX_VALID and TX_READY are both high.
  - After a transfer, SEND goes to:
    - LOAD_WAIT or SHIFT, if a LOAD or READ byte count is below NBYTES;
    - IDLE otherwise.
  - When the final LOAD byte's transfer completes, CFG_DONE is set.
- Status byte = {CFG_DONE, OVR, TOUT, UNKNOWN, 4'h0}. The transfer of a status byte clears OVR, TOUT and UNKNOWN. CFG_DONE is not cleared.
- An RX_VALID in SHIFT or SEND is dropped and sets the sticky OVR flag. The host paces itself on the echoed byte.
- An RX_VALID in LOAD_WAIT on the same cycle the timeout expires: the timeout wins and the byte is dropped; OVR is not set.
- After a full LOAD, the chain holds the new data and the host has received the previous NBYTES bytes in order.
- After READ, the chain is unchanged, because 8*NBYTES = CHAIN_LEN.

## Timing
- Reset values:
  - TX_VALID=0, TX_DATA=0x00.
  - SHIFT_ENABLE=0, SHIFT_HEAD=0.
  - BUSY=0, CFG_DONE=0, ERROR=0.
  - All flags and counters 0; state IDLE.
- Reset asserted mid-operation aborts immediately and leaves the chain partially shifted. No further SHIFT_ENABLE occurs.
- LOAD data byte: RX_VALID at cycle t gives SHIFT_ENABLE high on cycles t+1..t+8 and TX_VALID high from t+9.
- READ command: RX_VALID at t gives SHIFT_ENABLE high on t+1..t+8.
- STATUS command: RX_VALID at t gives TX_VALID at t+1.
- Between READ bytes: transfer at cycle u means the next SHIFT_ENABLE run starts at u+1.
- SHIFT_ENABLE is never high outside SHIFT. Exactly 8*NBYTES enable cycles per completed LOAD or READ.
- TX_DATA is stable whenever TX_VALID is high. TX_VALID drops the cycle after transfer unless the next byte is immediately ready (status only).
- The timeout counter runs only in LOAD_WAIT. It counts cycles since entry or since the last accepted byte.

## Test plan
- CHAIN_LEN=32, behavioural chain model preloaded with 0x00000000. Send LOAD then 0x11,0x22,0x33,0x44.
  - Echoes are 0x00 x4; CFG_DONE=1 after the 4th transfer.
  - A second LOAD of 0xAA x4 echoes 0x11,0x22,0x33,0x44.
- READ after that load: TX bytes are 0xAA x4 and chain contents are unchanged. Exactly 32 SHIFT_ENABLE cycles; TX_READY held low for 5 cycles per byte to check TX_DATA stability.
- TIMEOUT=50: LOAD then 0x5A, then silence.
  - Return to IDLE 50 cycles after the echo transfer; CFG_DONE=0, ERROR=1.
  - STATUS returns 0x20; a second STATUS returns 0x00.
- Overrun: send a second byte during SHIFT of a LOAD byte. It is ignored (8 enables only) and a later STATUS reports bit6 set.
- Unknown command 0x7F then STATUS: response 0x10; BUSY stays low after 0x7F.
- RESET pulsed on the 4th SHIFT_ENABLE cycle of a LOAD: next cycle all outputs are at reset values, and a subsequent STATUS returns 0x00.

Source files
------------

// File: rtl/cfg_chain_ctrl.sv
// rtl/cfg_chain_ctrl.sv - UART-framed configuration chain loader with readback and status
// Shifts CHAIN_LEN bits LSB first and echoes the displaced chain bytes to the host.
module cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int TIMEOUT   = 1000000
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       RX_VALID,
  input  logic [7:0] RX_DATA,
  input  logic       TX_READY,
  output logic       TX_VALID,
  output logic [7:0] TX_DATA,
  output logic       SHIFT_HEAD,
  input  logic       SHIFT_TAIL,
  output logic       SHIFT_ENABLE,
  output logic       BUSY,
  output logic       CFG_DONE,
  output logic       ERROR
);
  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int TCW    = $clog2(TIMEOUT + 1);

  generate
    if (CHAIN_LEN <= 0 || (CHAIN_LEN % 8) != 0) begin : g_bad_len
      $error("cfg_chain_ctrl: CHAIN_LEN must be a positive multiple of 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_LOAD_WAIT, S_SHIFT, S_SEND} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_READ, OP_STATUS} op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     rb_q, rb_d;
  logic [2:0]     bit_q, bit_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic [BCW-1:0] byte_nxt;
  logic [TCW-1:0] tout_cnt_q, tout_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           cfg_done_q, cfg_done_d;
  logic           ovr_q, ovr_d;
  logic           tout_q, tout_d;
  logic           unk_q, unk_d;

  assign byte_nxt = byte_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rb_d       = rb_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tout_cnt_d = '0;
    tx_data_d  = tx_data_q;
    cfg_done_d = cfg_done_q;
    ovr_d      = ovr_q;
    tout_d     = tout_q;
    unk_d      = unk_q;

    case (state_q)
      S_IDLE: begin
        if (RX_VALID) begin
          case (RX_DATA)
            8'h01: begin
              op_d       = OP_LOAD;
              cfg_done_d = 1'b0;
              byte_d     = '0;
              state_d    = S_LOAD_WAIT;
            end
            8'h02: begin
              op_d    = OP_READ;
              byte_d  = '0;
              bit_d   = 3'd0;
              state_d = S_SHIFT;
            end
            8'h03: begin
              op_d      = OP_STATUS;
              tx_data_d = {cfg_done_q, ovr_q, tout_q, unk_q, 4'h0};
              state_d   = S_SEND;
            end
            default: unk_d = 1'b1;
          endcase
        end
      end
      S_LOAD_WAIT: begin
        // Expiry beats a coincident data byte, which is silently dropped.
        if (tout_cnt_q == TCW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else if (RX_VALID) begin
          data_d  = RX_DATA;
          bit_d   = 3'd0;
          state_d = S_SHIFT;
        end else begin
          tout_cnt_d = tout_cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        rb_d[bit_q] = SHIFT_TAIL;
        bit_d       = bit_q + 3'd1;
        if (RX_VALID) ovr_d = 1'b1;
        if (bit_q == 3'd7) begin
          tx_data_d = rb_d;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (TX_READY) begin
          if (op_q == OP_STATUS) begin
            ovr_d   = 1'b0;
            tout_d  = 1'b0;
            unk_d   = 1'b0;
            state_d = S_IDLE;
          end else if (byte_nxt == BCW'(NBYTES)) begin
            if (op_q == OP_LOAD) cfg_done_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_nxt;
            bit_d   = 3'd0;
            state_d = (op_q == OP_LOAD) ? S_LOAD_WAIT : S_SHIFT;
          end
        end
        // A byte arriving while we talk is an overrun even if flags were just read.
        if (RX_VALID) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LOAD;
      data_q     <= '0;
      rb_q       <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tout_cnt_q <= '0;
      tx_data_q  <= '0;
      cfg_done_q <= 1'b0;
      ovr_q      <= 1'b0;
      tout_q     <= 1'b0;
      unk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      rb_q       <= rb_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      tout_cnt_q <= tout_cnt_d;
      tx_data_q  <= tx_data_d;
      cfg_done_q <= cfg_done_d;
      ovr_q      <= ovr_d;
      tout_q     <= tout_d;
      unk_q      <= unk_d;
    end
  end

  // Rotate mode feeds the tail straight back so a READ leaves the chain intact.
  assign SHIFT_ENABLE = (state_q == S_SHIFT);
  assign SHIFT_HEAD   = (state_q != S_SHIFT) ? 1'b0 :
                        (op_q == OP_LOAD)    ? data_q[bit_q] : SHIFT_TAIL;
  assign TX_VALID     = (state_q == S_SEND);
  assign TX_DATA      = tx_data_q;
  assign BUSY         = (state_q != S_IDLE);
  assign CFG_DONE     = cfg_done_q;
  assign ERROR        = ovr_q | tout_q | unk_q;

endmodule
